// File: rtl/imem_program_encoder_pkg.sv
// imem_program_encoder_pkg: shared ISA opcodes, field positions and loader states
package imem_program_encoder_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;

    localparam int OP_LSB    = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_LSB = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_program_encoder_packer.sv
// imem_program_encoder_packer: packs decoded fields into a 32-bit ISA word and flags legal opcodes
module imem_program_encoder_packer
    import imem_program_encoder_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shamt,
    input  logic [4:0]  aluop,
    input  logic [16:0] imm,
    input  logic [26:0] target,
    output logic [31:0] word,
    output logic        legal
);

    // select the layout by opcode; fields a layout does not use stay zero
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (opcode)
            OP_R:                                 word = {opcode, rd, rs, rt, shamt, aluop, 2'b00};
            OP_ADDI, OP_BNE, OP_BLT, OP_SW, OP_LW: word = {opcode, rd, rs, imm};
            OP_J, OP_JAL:                         word = {opcode, target};
            OP_JR:                                word = {opcode, rd, 22'b0};
            default:                              legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/imem_program_encoder.sv
// imem_program_encoder: streams decoded instructions into imem as packed words, flagging bad loads
module imem_program_encoder
    import imem_program_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    input  logic [26:0]       in_target,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic [ADDR_W:0]   instr_count,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam int CW = ADDR_W + 1;

    state_t      state, nxt;
    logic [31:0] word;
    logic        legal, go, xfer, full, wr, ovf;

    imem_program_encoder_packer u_pack (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs     (in_rs),
        .rt     (in_rt),
        .shamt  (in_shamt),
        .aluop  (in_aluop),
        .imm    (in_imm),
        .target (in_target),
        .word   (word),
        .legal  (legal)
    );

    assign in_ready = state == S_LOAD;

    // transfer qualification and next-state selection
    always_comb begin
        go   = start & (state == S_IDLE | state == S_DONE);
        xfer = in_valid & in_ready;
        full = instr_count == CW'(DEPTH);
        wr   = xfer & legal & ~full;
        ovf  = xfer & legal & full;
        nxt  = state;
        case (state)
            S_IDLE:  nxt = go ? S_LOAD : S_IDLE;
            S_LOAD:  nxt = ovf ? S_DONE : (xfer & in_last) ? S_FLUSH : S_LOAD;
            S_FLUSH: nxt = S_DONE;
            S_DONE:  nxt = go ? S_LOAD : S_DONE;
            default: nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    // write port, counter, completion pulse and sticky error flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_wren    <= 1'b0;
            imem_addr    <= ADDR_W'(BASE_ADDR);
            imem_data    <= '0;
            instr_count  <= '0;
            done         <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            imem_wren <= wr;
            done      <= state != S_DONE && nxt == S_DONE;
            if (go) begin
                imem_addr    <= ADDR_W'(BASE_ADDR);
                instr_count  <= '0;
                err_illegal  <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (wr) begin
                imem_addr   <= ADDR_W'(BASE_ADDR) + instr_count[ADDR_W-1:0];
                imem_data   <= word;
                instr_count <= instr_count + CW'(1);
            end
            if (xfer & ~legal) err_illegal <= 1'b1;
            if (ovf) err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_program_encoder.sv
// tb_imem_program_encoder: directed vectors with hand-computed words for the imem loader
module tb_imem_program_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0, in_aluop = '0;
    logic [16:0] in_imm = '0;
    logic [26:0] in_target = '0;
    logic        in_ready, imem_wren, done, err_illegal, err_overflow;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [12:0] instr_count;

    int total = 0;
    int bad = 0;
    int nw = 0;
    logic [11:0] log_addr [64];
    logic [31:0] log_data [64];

    imem_program_encoder #(.ADDR_W(12), .BASE_ADDR(0), .DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_opcode    (in_opcode),
        .in_rd        (in_rd),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_shamt     (in_shamt),
        .in_aluop     (in_aluop),
        .in_imm       (in_imm),
        .in_target    (in_target),
        .imem_wren    (imem_wren),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr_count  (instr_count),
        .done         (done),
        .err_illegal  (err_illegal),
        .err_overflow (err_overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imem_wren && nw < 64) begin
            log_addr[nw] = imem_addr;
            log_data[nw] = imem_data;
            nw = nw + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] alu,
                        input logic [16:0] imm, input logic [26:0] tgt, input logic last);
        in_valid = 1'b1;
        in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_shamt = sh; in_aluop = alu; in_imm = imm; in_target = tgt; in_last = last;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else step();
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        int w0;
        #1;
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_wren", {31'b0, imem_wren}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_errs", {30'b0, err_illegal, err_overflow}, 0);
        chk("rst_addr", {20'b0, imem_addr}, 0);
        chk("rst_data", imem_data, 0);
        chk("rst_count", {19'b0, instr_count}, 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("idle_ready", {31'b0, in_ready}, 0);

        pulse_start();
        chk("load_ready", {31'b0, in_ready}, 1);
        send(5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
        in_valid = 1'b0;
        chk("r_wren", {31'b0, imem_wren}, 1);
        chk("r_addr", {20'b0, imem_addr}, 0);
        chk("r_data", imem_data, 32'h00C22000);
        chk("r_count", {19'b0, instr_count}, 1);
        step();
        chk("r_done", {31'b0, done}, 1);
        chk("done_ready", {31'b0, in_ready}, 0);
        step();
        chk("done_pulse_end", {31'b0, done}, 0);

        send(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
        step();
        in_valid = 1'b0;
        chk("done_nowrite", {31'b0, imem_wren}, 0);
        chk("done_count", {19'b0, instr_count}, 1);

        w0 = nw;
        start = 1'b1;
        step();
        send(5'b00101, 5'd1, 5'd0, 5'd7, 5'd7, 5'd7, 17'd5, 27'h7FFFFFF, 1'b0);
        send(5'b01000, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 17'd4, 27'd0, 1'b0);
        send(5'b00001, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 17'h1FFFF, 27'd100, 1'b0);
        send(5'b00100, 5'd31, 5'd17, 5'd3, 5'd3, 5'd3, 17'h1ABCD, 27'h5555555, 1'b1);
        in_valid = 1'b0;
        start = 1'b0;
        wait_done();
        chk("s_nwrites", nw - w0, 4);
        chk("s_d0", log_data[w0], 32'h28400005);
        chk("s_d1", log_data[w0 + 1], 32'h40820004);
        chk("s_d2", log_data[w0 + 2], 32'h08000064);
        chk("s_d3", log_data[w0 + 3], 32'h27C00000);
        chk("s_a0", {20'b0, log_addr[w0]}, 0);
        chk("s_a3", {20'b0, log_addr[w0 + 3]}, 3);
        chk("s_count", {19'b0, instr_count}, 4);
        chk("s_errs", {30'b0, err_illegal, err_overflow}, 0);
        step();

        w0 = nw;
        pulse_start();
        send(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
        send(5'b10101, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 17'd4, 27'd4, 1'b0);
        chk("ill_wren", {31'b0, imem_wren}, 0);
        chk("ill_flag", {31'b0, err_illegal}, 1);
        chk("ill_addr", {20'b0, imem_addr}, 0);
        send(5'b01000, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 17'd4, 27'd0, 1'b1);
        in_valid = 1'b0;
        wait_done();
        chk("ill_nwrites", nw - w0, 2);
        chk("ill_a1", {20'b0, log_addr[w0 + 1]}, 1);
        chk("ill_d1", log_data[w0 + 1], 32'h40820004);
        chk("ill_count", {19'b0, instr_count}, 2);
        step();
        chk("ill_sticky", {31'b0, err_illegal}, 1);
        pulse_start();
        chk("ill_cleared", {31'b0, err_illegal}, 0);

        w0 = nw;
        for (int i = 0; i < 5; i++)
            send(5'b00101, 5'(i), 5'd0, 5'd0, 5'd0, 5'd0, 17'(i), 27'd0, 1'b0);
        in_valid = 1'b0;
        chk("ovf_wren", {31'b0, imem_wren}, 0);
        chk("ovf_done", {31'b0, done}, 1);
        chk("ovf_flag", {31'b0, err_overflow}, 1);
        chk("ovf_count", {19'b0, instr_count}, 4);
        step();
        chk("ovf_nwrites", nw - w0, 4);
        chk("ovf_d3", log_data[w0 + 3], 32'h28C00003);
        chk("ovf_done_end", {31'b0, done}, 0);

        pulse_start();
        send(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd1, 1'b0);
        send(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd2, 1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_wren", {31'b0, imem_wren}, 0);
        chk("ar_addr", {20'b0, imem_addr}, 0);
        chk("ar_data", imem_data, 0);
        chk("ar_count", {19'b0, instr_count}, 0);
        chk("ar_ready", {31'b0, in_ready}, 0);
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        pulse_start();
        send(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd100, 1'b1);
        in_valid = 1'b0;
        chk("rl_addr", {20'b0, imem_addr}, 0);
        chk("rl_data", imem_data, 32'h08000064);
        chk("rl_count", {19'b0, instr_count}, 1);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
